// File: rtl/npu_wr_arbiter_if.sv
// Bundle between the two write sources, the NPU write port and status.
// master: the side driving sources/NPU feedback; slave: the arbiter.
interface npu_wr_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req_w;
    logic              req_d;
    logic              gnt_w;
    logic              gnt_d;
    logic              src_w_vld;
    logic              src_w_last;
    logic [DATA_W-1:0] src_w_data;
    logic              src_d_vld;
    logic              src_d_last;
    logic [DATA_W-1:0] src_d_data;
    logic              npu_wr_sop;
    logic              npu_wr_eop;
    logic              npu_wr_vld;
    logic [DATA_W-1:0] npu_wr_data;
    logic              npu_wr_sel;
    logic              npu_wr_err;
    logic              busy;
    logic              err_flag;
    logic              err_clr;
    logic [15:0]       pkt_cnt_w;
    logic [15:0]       pkt_cnt_d;

    modport master (
        output req_w, req_d,
        output src_w_vld, src_w_last, src_w_data,
        output src_d_vld, src_d_last, src_d_data,
        output npu_wr_err, err_clr,
        input  gnt_w, gnt_d,
        input  npu_wr_sop, npu_wr_eop, npu_wr_vld,
        input  npu_wr_data, npu_wr_sel,
        input  busy, err_flag, pkt_cnt_w, pkt_cnt_d
    );

    modport slave (
        input  req_w, req_d,
        input  src_w_vld, src_w_last, src_w_data,
        input  src_d_vld, src_d_last, src_d_data,
        input  npu_wr_err, err_clr,
        output gnt_w, gnt_d,
        output npu_wr_sop, npu_wr_eop, npu_wr_vld,
        output npu_wr_data, npu_wr_sel,
        output busy, err_flag, pkt_cnt_w, pkt_cnt_d
    );
endinterface

// File: rtl/npu_wr_arbiter.sv
// Packet-level round-robin arbiter merging weight and data write
// streams onto one NPU write port, with error flush and idle timeout.
module npu_wr_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst_n,
    npu_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(TIMEOUT + 1);
    localparam logic [IDW-1:0] TO_M1 = IDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_FLUSH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rr_w;
    logic              r_sel;
    logic              r_gnt_w;
    logic              r_gnt_d;
    logic              r_first;
    logic              r_vld;
    logic              r_sop;
    logic              r_eop;
    logic              r_err;
    logic [DATA_W-1:0] r_data;
    logic [IDW-1:0]    r_idle;
    logic [15:0]       r_cnt_w;
    logic [15:0]       r_cnt_d;

    logic              w_vld;
    logic              w_last;
    logic [DATA_W-1:0] w_data;
    logic              w_active;
    logic              w_tmo;
    logic              w_pick_w;
    logic              w_grant;
    logic              w_fwd;
    logic              w_done;
    logic              w_err_set;
    logic              w_tmo_eop;

    // Only the granted source is ever looked at.
    assign w_vld    = r_sel ? bus.src_w_vld  : bus.src_d_vld;
    assign w_last   = r_sel ? bus.src_w_last : bus.src_d_last;
    assign w_data   = r_sel ? bus.src_w_data : bus.src_d_data;
    assign w_active = (r_state == S_XFER) || (r_state == S_FLUSH);
    assign w_tmo    = w_active && !w_vld && (r_idle == TO_M1);
    assign w_pick_w = bus.req_w && (!bus.req_d || r_rr_w);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_fwd     = 1'b0;
        w_done    = 1'b0;
        w_err_set = 1'b0;
        w_tmo_eop = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_w || bus.req_d) begin
                    w_grant = 1'b1;
                    w_next  = S_GRANT;
                end
            end
            S_GRANT: w_next = S_XFER;
            S_XFER: begin
                if (bus.npu_wr_err) begin
                    w_err_set = 1'b1;
                    // An error on the closing beat has nothing left to flush.
                    w_next = (w_vld && w_last) ? S_IDLE : S_FLUSH;
                end else if (w_vld) begin
                    w_fwd = 1'b1;
                    if (w_last) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_tmo) begin
                    w_err_set = 1'b1;
                    w_tmo_eop = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_vld && w_last) begin
                    w_next = S_IDLE;
                end else if (w_tmo) begin
                    w_err_set = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, source select and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_w  <= 1'b1;
            r_sel   <= 1'b0;
            r_gnt_w <= 1'b0;
            r_gnt_d <= 1'b0;
        end else if (w_grant) begin
            r_rr_w  <= !w_pick_w;
            r_sel   <= w_pick_w;
            r_gnt_w <= w_pick_w;
            r_gnt_d <= !w_pick_w;
        end else if (w_next == S_IDLE) begin
            r_gnt_w <= 1'b0;
            r_gnt_d <= 1'b0;
        end
    end

    // Registered NPU write port; data forced to 0 when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_data  <= '0;
            r_first <= 1'b0;
        end else begin
            r_vld  <= w_fwd;
            r_sop  <= w_fwd && r_first;
            r_eop  <= (w_fwd && w_last) || w_tmo_eop;
            r_data <= w_fwd ? w_data : '0;
            if (w_grant)    r_first <= 1'b1;
            else if (w_fwd) r_first <= 1'b0;
        end
    end

    // Idle counter: cleared by any granted beat or outside a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_idle <= '0;
        else if (w_active && !w_vld) r_idle <= r_idle + IDW'(1);
        else                         r_idle <= '0;
    end

    // Completed-packet counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_w <= '0;
            r_cnt_d <= '0;
        end else if (w_done) begin
            if (r_sel) r_cnt_w <= r_cnt_w + 16'd1;
            else       r_cnt_d <= r_cnt_d + 16'd1;
        end
    end

    // Sticky error; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_err <= 1'b0;
        else if (w_err_set)   r_err <= 1'b1;
        else if (bus.err_clr) r_err <= 1'b0;
    end

    assign bus.gnt_w       = r_gnt_w;
    assign bus.gnt_d       = r_gnt_d;
    assign bus.npu_wr_vld  = r_vld;
    assign bus.npu_wr_sop  = r_sop;
    assign bus.npu_wr_eop  = r_eop;
    assign bus.npu_wr_data = r_data;
    assign bus.npu_wr_sel  = r_sel;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.err_flag    = r_err;
    assign bus.pkt_cnt_w   = r_cnt_w;
    assign bus.pkt_cnt_d   = r_cnt_d;
endmodule

// File: tb/tb_npu_wr_arbiter.sv
// Randomized bench for npu_wr_arbiter: packet-level reference model
// (expected beat lists, round-robin pointer, counters, error flag).
module tb_npu_wr_arbiter;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    npu_wr_arbiter_if #(.DATA_W(DW)) bus();

    npu_wr_arbiter #(
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_last_w;
    logic [15:0] m_cnt_w;
    logic [15:0] m_cnt_d;
    bit          m_err;

    // Observed output beats: {sel, sop, eop, data}.
    logic [DW+2:0] obs_q[$];
    int            z_viol = 0;

    // Record every output beat; flag payload/sop while not valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.npu_wr_vld === 1'b1)
                obs_q.push_back({bus.npu_wr_sel, bus.npu_wr_sop,
                                 bus.npu_wr_eop, bus.npu_wr_data});
            else if (bus.npu_wr_data !== '0 || bus.npu_wr_sop !== 1'b0)
                z_viol++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.req_w      = 1'b0;
        bus.req_d      = 1'b0;
        bus.src_w_vld  = 1'b0;
        bus.src_w_last = 1'b0;
        bus.src_w_data = '0;
        bus.src_d_vld  = 1'b0;
        bus.src_d_last = 1'b0;
        bus.src_d_data = '0;
        bus.npu_wr_err = 1'b0;
        bus.err_clr    = 1'b0;
    endtask

    // Drive the granted source; the other one gets random noise.
    task automatic drive_src(input bit w, input logic v, input logic l,
                             input logic [DW-1:0] d);
        if (w) begin
            bus.src_w_vld  = v;
            bus.src_w_last = l;
            bus.src_w_data = d;
            bus.src_d_vld  = 1'($urandom);
            bus.src_d_last = 1'($urandom);
            bus.src_d_data = DW'($urandom);
        end else begin
            bus.src_d_vld  = v;
            bus.src_d_last = l;
            bus.src_d_data = d;
            bus.src_w_vld  = 1'($urandom);
            bus.src_w_last = 1'($urandom);
            bus.src_w_data = DW'($urandom);
        end
    endtask

    task automatic model_reset();
        m_last_w = 1'b0;
        m_cnt_w  = '0;
        m_cnt_d  = '0;
        m_err    = 1'b0;
        obs_q.delete();
    endtask

    // One packet from request to grant release, checked against the model.
    task automatic do_pkt(input bit rw, input bit rd, input int nb,
                          input int err_at, input int maxgap,
                          input bit clr_with_err, input bit fixed,
                          input logic [DW-1:0] base);
        bit            ew;
        int            n;
        int            eo;
        logic          f;
        logic          l;
        logic [DW-1:0] d;
        logic [DW+2:0] exp_q[$];
        obs_q.delete();
        ew = rw && (!rd || !m_last_w);
        if (rw) bus.req_w = 1'b1;
        if (rd) bus.req_d = 1'b1;
        n = 0;
        while (bus.gnt_w !== 1'b1 && bus.gnt_d !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.gnt_w, bus.gnt_d} !== {ew, !ew}) begin
            errors++;
            $display("FAIL grant: got w=%b d=%b, expected w=%b d=%b",
                     bus.gnt_w, bus.gnt_d, ew, !ew);
            if (bus.gnt_w !== 1'b1 && bus.gnt_d !== 1'b1) begin
                idle_inputs();
                return;
            end
        end
        if (ew) bus.req_w = 1'b0;
        else    bus.req_d = 1'b0;
        m_last_w = ew;
        eo = (err_at < 0) ? nb : err_at;
        for (int i = 0; i < nb; i++) begin
            d = fixed ? base + DW'(i) : DW'($urandom);
            f = (i == 0);
            l = (i == nb - 1) && (err_at < 0);
            if (i < eo) exp_q.push_back({ew, f, l, d});
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
                drive_src(ew, 1'b0, 1'b0, '0);
                bus.npu_wr_err = 1'b0;
                bus.err_clr    = 1'b0;
            end
            @(posedge clk);
            #1;
            drive_src(ew, 1'b1, (i == nb - 1), d);
            bus.npu_wr_err = (i == err_at);
            bus.err_clr    = clr_with_err && (i == err_at);
        end
        @(negedge clk);
        checks++;
        if ((ew ? bus.gnt_w : bus.gnt_d) !== 1'b1) begin
            errors++;
            $display("FAIL gnt_hold: grant=%b before last beat, expected 1",
                     ew ? bus.gnt_w : bus.gnt_d);
        end
        @(posedge clk);
        #1;
        bus.src_w_vld  = 1'b0;
        bus.src_d_vld  = 1'b0;
        bus.npu_wr_err = 1'b0;
        bus.err_clr    = 1'b0;
        @(negedge clk);
        #1;
        if (err_at < 0) begin
            if (ew) m_cnt_w = m_cnt_w + 16'd1;
            else    m_cnt_d = m_cnt_d + 16'd1;
        end else begin
            m_err = 1'b1;
        end
        checks++;
        if ({bus.gnt_w, bus.gnt_d, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL release: gnt_w/gnt_d/busy=%b%b%b, expected 000",
                     bus.gnt_w, bus.gnt_d, bus.busy);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL beat_count: got %0d beats, expected %0d",
                     obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL beat%0d: got sel/sop/eop/data=%h, expected %h",
                             k, obs_q[k], exp_q[k]);
                end
            end
        end
        checks++;
        if (bus.pkt_cnt_w !== m_cnt_w || bus.pkt_cnt_d !== m_cnt_d) begin
            errors++;
            $display("FAIL pkt_cnt: got w=%0d d=%0d, expected w=%0d d=%0d",
                     bus.pkt_cnt_w, bus.pkt_cnt_d, m_cnt_w, m_cnt_d);
        end
        checks++;
        if (bus.err_flag !== m_err) begin
            errors++;
            $display("FAIL err_flag: got %b, expected %b", bus.err_flag, m_err);
        end
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.err_flag !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err_flag=%b, expected 0", bus.err_flag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.npu_wr_vld, bus.npu_wr_sop, bus.npu_wr_eop, bus.npu_wr_sel,
             bus.gnt_w, bus.gnt_d, bus.busy, bus.err_flag} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000000",
                     {bus.npu_wr_vld, bus.npu_wr_sop, bus.npu_wr_eop,
                      bus.npu_wr_sel, bus.gnt_w, bus.gnt_d, bus.busy,
                      bus.err_flag});
        end
        checks++;
        if (bus.npu_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 0", bus.npu_wr_data);
        end
        checks++;
        if (bus.pkt_cnt_w !== 16'd0 || bus.pkt_cnt_d !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got w=%0d d=%0d, expected 0 0",
                     bus.pkt_cnt_w, bus.pkt_cnt_d);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, expected 0", bus.busy);
        end
    endtask

    task automatic test_single_w();
        do_pkt(1'b1, 1'b0, 4, -1, 0, 1'b0, 1'b1, 32'hA0);
        checks++;
        if (bus.pkt_cnt_w !== 16'd1) begin
            errors++;
            $display("FAIL cnt_w_one: got %0d, expected 1", bus.pkt_cnt_w);
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        do_pkt(1'b1, 1'b1, 2, -1, 0, 1'b0, 1'b0, '0);
        do_pkt(!m_last_w, m_last_w, 2, -1, 0, 1'b0, 1'b0, '0);
        do_pkt(1'b1, 1'b1, 2, -1, 0, 1'b0, 1'b0, '0);
        do_pkt(!m_last_w, m_last_w, 2, -1, 0, 1'b0, 1'b0, '0);
        checks++;
        if (bus.pkt_cnt_w !== 16'd2 || bus.pkt_cnt_d !== 16'd2) begin
            errors++;
            $display("FAIL rr_counts: got w=%0d d=%0d, expected 2 2",
                     bus.pkt_cnt_w, bus.pkt_cnt_d);
        end
    endtask

    task automatic test_single_beat();
        do_pkt(1'b0, 1'b1, 1, -1, 0, 1'b0, 1'b1, 32'h1234);
    endtask

    task automatic test_error_flush();
        do_pkt(1'b1, 1'b0, 5, 1, 0, 1'b1, 1'b0, '0);
        clear_err();
        @(posedge clk);
        #1;
        bus.npu_wr_err = 1'b1;
        @(posedge clk);
        #1;
        bus.npu_wr_err = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.err_flag !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: err_flag=%b busy=%b, expected 0 0",
                     bus.err_flag, bus.busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        obs_q.delete();
        bus.req_d = 1'b1;
        n = 0;
        while (bus.gnt_d !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_d = 1'b0;
        bus.src_w_vld = 1'b1;
        m_last_w = 1'b0;
        n = 0;
        while (bus.npu_wr_eop !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.src_w_vld = 1'b0;
        m_err = 1'b1;
        // One GRANT cycle, then TIMEOUT idle cycles in XFER.
        checks++;
        if (n != TO + 1) begin
            errors++;
            $display("FAIL tmo_delay: eop after %0d cycles, expected %0d",
                     n, TO + 1);
        end
        checks++;
        if ({bus.npu_wr_vld, bus.err_flag, bus.gnt_d, bus.busy} !== 4'b0100) begin
            errors++;
            $display("FAIL tmo_state: vld/err/gnt/busy=%b, expected 0100",
                     {bus.npu_wr_vld, bus.err_flag, bus.gnt_d, bus.busy});
        end
        #1;
        checks++;
        if (bus.pkt_cnt_w !== m_cnt_w || bus.pkt_cnt_d !== m_cnt_d ||
            obs_q.size() != 0) begin
            errors++;
            $display("FAIL tmo_cnt: w=%0d d=%0d beats=%0d, expected %0d %0d 0",
                     bus.pkt_cnt_w, bus.pkt_cnt_d, obs_q.size(),
                     m_cnt_w, m_cnt_d);
        end
        clear_err();
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        bus.req_w = 1'b1;
        n = 0;
        while (bus.gnt_w !== 1'b1 && bus.gnt_d !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive_src(bus.gnt_w, 1'b1, 1'b0, DW'($urandom));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.npu_wr_vld, bus.npu_wr_sop, bus.npu_wr_eop, bus.npu_wr_sel,
             bus.gnt_w, bus.gnt_d, bus.busy, bus.err_flag} !== 8'h00 ||
            bus.npu_wr_data !== '0) begin
            errors++;
            $display("FAIL rst_mid: ctrl=%b data=%h, expected all 0",
                     {bus.npu_wr_vld, bus.npu_wr_sop, bus.npu_wr_eop,
                      bus.npu_wr_sel, bus.gnt_w, bus.gnt_d, bus.busy,
                      bus.err_flag}, bus.npu_wr_data);
        end
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.npu_wr_eop !== 1'b0 || bus.npu_wr_vld !== 1'b0 ||
                bus.busy !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_after: %0d cycles with eop/vld/busy, expected 0",
                     bad);
        end
        do_pkt(1'b1, 1'b1, 3, -1, 1, 1'b0, 1'b0, '0);
        do_pkt(!m_last_w, m_last_w, 2, -1, 1, 1'b0, 1'b0, '0);
    endtask

    task automatic rand_pkt(input bit rw, input bit rd);
        int nb;
        int ea;
        nb = $urandom_range(1, 6);
        ea = -1;
        if (nb > 1 && $urandom_range(0, 4) == 0) ea = $urandom_range(0, nb - 2);
        do_pkt(rw, rd, nb, ea, $urandom_range(0, 3), 1'($urandom), 1'b0, '0);
    endtask

    task automatic test_random();
        int pat;
        for (int it = 0; it < 40; it++) begin
            pat = $urandom_range(0, 2);
            if (pat == 2) begin
                rand_pkt(1'b1, 1'b1);
                rand_pkt(!m_last_w, m_last_w);
            end else begin
                rand_pkt(pat == 0, pat == 1);
            end
            if (m_err && $urandom_range(0, 1) == 1) clear_err();
        end
        checks++;
        if (z_viol != 0) begin
            errors++;
            $display("FAIL idle_data: %0d idle cycles with data/sop, expected 0",
                     z_viol);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_w();
        test_round_robin();
        test_single_beat();
        test_error_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/npu_wr_arbiter.md
NPU_WR_ARBITER -- requirements
Module: npu_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of source and NPU beats.
REQ-002 Parameter TIMEOUT, default 255, maximum idle cycles inside a granted packet.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_w / req_d  input  1 each  weight / data source requests one packet.
REQ-006 gnt_w / gnt_d  output  1 each  grant to weight / data source, held for the whole packet.
REQ-007 src_w_vld, src_w_last, src_d_vld, src_d_last  input  1 each  beat valid / last beat of packet.
REQ-008 src_w_data / src_d_data  input  DATA_W  beat payload.
REQ-009 npu_wr_sop, npu_wr_eop, npu_wr_vld  output  1 each  NPU write packet framing.
REQ-010 npu_wr_data  output  DATA_W  NPU write payload.
REQ-011 npu_wr_sel  output  1  1 = weight packet, 0 = data packet; valid whenever npu_wr_vld=1.
REQ-012 npu_wr_err  input  1  NPU reports a write error.
REQ-013 busy  output  1  high when not in IDLE.
REQ-014 err_flag  output  1  sticky error indicator.
REQ-015 err_clr  input  1  clears err_flag.
REQ-016 pkt_cnt_w / pkt_cnt_d  output  16 each  completed-packet counters per source.

Function
REQ-017 FSM states IDLE, GRANT, XFER, FLUSH; IDLE -> GRANT when req_w|req_d.
REQ-018 Arbitration in IDLE is round-robin at packet granularity: when both request, the grant goes to the source not served last; the initial pointer after reset favours weight.
REQ-019 In GRANT, exactly one of gnt_w/gnt_d is driven high (registered); the FSM moves to XFER on the next cycle.
REQ-020 In XFER, each granted-source beat with vld=1 produces npu_wr_vld=1 with the same data and last flag exactly 1 cycle later; outputs are registered.
REQ-021 npu_wr_sop is asserted on the output cycle of the first beat of the packet only; npu_wr_eop is asserted on the output cycle of the beat that has last=1.
REQ-022 A single-beat packet (first beat has last=1) produces sop=eop=vld=1 in the same cycle.
REQ-023 The non-granted source's vld/data are ignored; npu_wr_data is 0 whenever npu_wr_vld=0.
REQ-024 An accepted last beat in XFER deasserts the grant on the next edge, increments the granted source's counter by 1 (wrapping at 65535 -> 0), updates the RR pointer, and returns to IDLE.
REQ-025 npu_wr_err=1 in XFER sets err_flag, stops forwarding (npu_wr_vld=0), and moves to FLUSH; FLUSH keeps the grant and drops beats until last=1, then returns to IDLE without incrementing the counter.
REQ-026 The idle counter resets on every granted beat; reaching TIMEOUT cycles in XFER or FLUSH sets err_flag, emits npu_wr_eop=1 with npu_wr_vld=0 if in XFER, drops the grant, and returns to IDLE without incrementing the counter.
REQ-027 When err_clr and a new error occur in the same cycle, err_flag remains 1.
REQ-028 A source dropping req while granted has no effect; the packet ends only on last or timeout.
REQ-029 npu_wr_err outside XFER is ignored.

Reset
REQ-030 While rst_n=0, all outputs are 0, counters are 0, the FSM is in IDLE, the RR pointer favours weight, and the idle counter is 0.
REQ-031 Reset asserted mid-packet aborts the packet immediately; after release no partial eop is emitted, and the source must re-request.

Verification
REQ-032 req_w only, 4 beats 0xA0..0xA3 with last on the 4th -> npu_wr_vld for 4 cycles, sop on 0xA0, eop on 0xA3, sel=1, pkt_cnt_w=1.
REQ-033 req_w and req_d high together from reset, 2-beat packets each -> weight served first, then data; a second simultaneous request -> weight again (alternation); pkt_cnt_w=pkt_cnt_d=2 after four packets.
REQ-034 Single-beat data packet 0x1234 with last=1 -> one cycle with sop=eop=vld=1, sel=0, data=0x1234.
REQ-035 npu_wr_err pulsed on beat 2 of a 5-beat packet -> err_flag=1, no further npu_wr_vld, grant held until the source's last beat, pkt_cnt unchanged; err_clr -> err_flag=0.
REQ-036 Grant issued, then the source stalls with TIMEOUT=8 -> after 8 idle cycles err_flag=1, eop pulse with vld=0, grant=0, busy=0.
REQ-037 rst_n pulsed low during beat 3 of a packet -> all outputs 0 on the same cycle, busy=0 and no eop after release.
